// File: rtl/bus_dev_port.sv
// Shared-bus device endpoint: FWFT TX FIFO drained by the arbiter, FWFT RX FIFO filled by arbiter pushes.
// Optional destination filter on RX enabled by defining BUS_DEV_RX_ID_FILTER_EN.
module bus_dev_port #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PCKG_SZ   = 16,
  parameter logic [7:0]  ID        = 8'h00,
  parameter logic [7:0]  BROADCAST = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [PCKG_SZ-1:0] tx_data,
  output logic               tx_full,
  output logic               tx_ovf,
  output logic               pndng,
  output logic [PCKG_SZ-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [PCKG_SZ-1:0] D_push,
  output logic               rx_valid,
  output logic [PCKG_SZ-1:0] rx_data,
  input  logic               rx_rd,
  output logic [7:0]         rx_drop_cnt,
  output logic [7:0]         rx_misaddr_cnt
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

`ifdef BUS_DEV_RX_ID_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  // ---------------- TX FIFO ----------------
  logic [PCKG_SZ-1:0] tx_mem [DEPTH];
  logic [AW-1:0]      tx_wp, tx_rp;
  logic [AW:0]        tx_cnt;
  logic               tx_do_wr, tx_do_rd;

  assign pndng   = (tx_cnt != '0);
  assign tx_full = (tx_cnt == FULL_CNT);
  assign D_pop   = pndng ? tx_mem[tx_rp] : '0;

  // A pop frees a slot in the same edge, so a write to a full FIFO is accepted alongside it.
  always_comb begin
    tx_do_rd = pop && pndng;
    tx_do_wr = tx_wr && (!tx_full || tx_do_rd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (tx_do_wr) tx_wp <= tx_wp + 1'b1;
      if (tx_do_rd) tx_rp <= tx_rp + 1'b1;
      case ({tx_do_wr, tx_do_rd})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
      if (tx_wr && !tx_do_wr) tx_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_do_wr) tx_mem[tx_wp] <= tx_data;
  end

  // ---------------- RX FIFO ----------------
  logic [PCKG_SZ-1:0] rx_mem [DEPTH];
  logic [AW-1:0]      rx_wp, rx_rp;
  logic [AW:0]        rx_cnt;
  logic [7:0]         dest;
  logic               addr_hit, accept, rx_full, rx_do_wr, rx_do_rd, rx_drop, rx_reject;

  assign rx_valid = (rx_cnt != '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_data  = rx_valid ? rx_mem[rx_rp] : '0;

  // Unfiltered build forces accept high, so the misaddress counter can never leave zero.
  always_comb begin
    dest      = D_push[PCKG_SZ-1:PCKG_SZ-8];
    addr_hit  = (dest == ID) || (dest == BROADCAST);
    accept    = !FILTER || addr_hit;
    rx_do_rd  = rx_rd && rx_valid;
    rx_do_wr  = push && accept && (!rx_full || rx_do_rd);
    rx_drop   = push && accept && rx_full && !rx_do_rd;
    rx_reject = push && !accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wp          <= '0;
      rx_rp          <= '0;
      rx_cnt         <= '0;
      rx_drop_cnt    <= '0;
      rx_misaddr_cnt <= '0;
    end else begin
      if (rx_do_wr) rx_wp <= rx_wp + 1'b1;
      if (rx_do_rd) rx_rp <= rx_rp + 1'b1;
      case ({rx_do_wr, rx_do_rd})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
      if (rx_drop && (rx_drop_cnt != '1))       rx_drop_cnt    <= rx_drop_cnt + 1'b1;
      if (rx_reject && (rx_misaddr_cnt != '1))  rx_misaddr_cnt <= rx_misaddr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_do_wr) rx_mem[rx_wp] <= D_push;
  end

endmodule

// File: tb/tb_bus_dev_port.sv
// Scoreboard bench for bus_dev_port: stimulus queues expected FIFO outputs, a negedge monitor checks them.
module tb_bus_dev_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_wr = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_full, tx_ovf, pndng;
  logic [15:0] D_pop;
  logic        pop = 1'b0;
  logic        push = 1'b0;
  logic [15:0] D_push = '0;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_rd = 1'b0;
  logic [7:0]  rx_drop_cnt, rx_misaddr_cnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] tx_exp [$];
  logic [15:0] rx_exp [$];

  bus_dev_port #(.DEPTH(8), .PCKG_SZ(16), .ID(8'h03), .BROADCAST(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_ovf(tx_ovf),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
    .rx_drop_cnt(rx_drop_cnt), .rx_misaddr_cnt(rx_misaddr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake that consumes a FIFO head must match the scoreboard front.
  always @(negedge clk) begin
    if (pop && pndng) begin
      if (tx_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_pop_unexpected: got 0x%0h expected nothing", D_pop);
      end else chk("tx_pop_data", 32'(D_pop), 32'(tx_exp.pop_front()));
    end
    if (rx_rd && rx_valid) begin
      if (rx_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_rd_unexpected: got 0x%0h expected nothing", rx_data);
      end else chk("rx_rd_data", 32'(rx_data), 32'(rx_exp.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic tx_write(input logic [15:0] d, input bit store);
    tx_wr = 1'b1; tx_data = d;
    if (store) tx_exp.push_back(d);
    tick();
    tx_wr = 1'b0;
  endtask

  task automatic tx_pop(input int n);
    pop = 1'b1;
    repeat (n) tick();
    pop = 1'b0;
  endtask

  task automatic rx_push(input logic [15:0] d, input bit store);
    push = 1'b1; D_push = d;
    if (store) rx_exp.push_back(d);
    tick();
    push = 1'b0;
  endtask

  task automatic rx_read(input int n);
    rx_rd = 1'b1;
    repeat (n) tick();
    rx_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit filt;
`ifdef BUS_DEV_RX_ID_FILTER_EN
    filt = 1'b1;
`else
    filt = 1'b0;
`endif
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_pndng", 32'(pndng), 0);
    chk("rst_tx_full", 32'(tx_full), 0);
    chk("rst_tx_ovf", 32'(tx_ovf), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_d_pop", 32'(D_pop), 0);
    chk("rst_drop", 32'(rx_drop_cnt), 0);
    chk("rst_misaddr", 32'(rx_misaddr_cnt), 0);

    // Basic FWFT TX
    tx_write(16'h0123, 1'b1);
    chk("wr_pndng_lat", 32'(pndng), 1);
    chk("wr_head", 32'(D_pop), 32'h0123);
    tx_write(16'h0456, 1'b1);
    tx_pop(1);
    chk("pop_next_head", 32'(D_pop), 32'h0456);
    tx_pop(1);
    chk("pop_empty_pndng", 32'(pndng), 0);

    // Fill, overflow, drain with pointer wrap
    for (int i = 1; i <= 9; i++) begin
      tx_write(16'h1000 + 16'(i), i <= 8);
      if (i == 8) begin
        chk("full_after_8", 32'(tx_full), 1);
        chk("no_ovf_at_8", 32'(tx_ovf), 0);
      end
    end
    chk("ovf_after_9", 32'(tx_ovf), 1);
    tx_pop(8);
    chk("drained_pndng", 32'(pndng), 0);
    chk("drained_full", 32'(tx_full), 0);

    // Pop on empty ignored; write+pop on empty yields one entry
    tx_pop(1);
    chk("empty_pop_pndng", 32'(pndng), 0);
    tx_wr = 1'b1; tx_data = 16'h0777; pop = 1'b1; tx_exp.push_back(16'h0777);
    tick();
    tx_wr = 1'b0; pop = 1'b0;
    chk("wrpop_empty_pndng", 32'(pndng), 1);
    chk("wrpop_empty_head", 32'(D_pop), 32'h0777);
    tx_pop(1);

    // Full with simultaneous write and pop
    for (int i = 1; i <= 8; i++) tx_write(16'h2000 + 16'(i), 1'b1);
    tx_wr = 1'b1; tx_data = 16'h0AAA; pop = 1'b1; tx_exp.push_back(16'h0AAA);
    tick();
    tx_wr = 1'b0; pop = 1'b0;
    chk("wrpop_full_stays", 32'(tx_full), 1);
    tx_pop(7);
    chk("last_is_aaa", 32'(D_pop), 32'h0AAA);
    tx_pop(1);
    chk("tx_q_empty", 32'(tx_exp.size()), 0);
    chk("ovf_sticky", 32'(tx_ovf), 1);

    // RX filter
    rx_push(16'h03BE, 1'b1);
    chk("rx_valid_lat", 32'(rx_valid), 1);
    rx_push(16'hFF11, 1'b1);
    rx_push(16'h0522, !filt);
    chk("misaddr", 32'(rx_misaddr_cnt), filt ? 32'd1 : 32'd0);
    rx_read(filt ? 2 : 3);
    chk("rx_drained", 32'(rx_valid), 0);
    chk("rx_empty_data", 32'(rx_data), 0);

    // RX overflow and saturation
    for (int i = 0; i < 8; i++) rx_push(16'h0300 + 16'(i), 1'b1);
    rx_push(16'h03A0, 1'b0);
    rx_push(16'h03A1, 1'b0);
    chk("drop_2", 32'(rx_drop_cnt), 2);
    rx_rd = 1'b1;
    rx_push(16'h03B0, 1'b1);
    rx_rd = 1'b0;
    chk("drop_still_2", 32'(rx_drop_cnt), 2);
    for (int i = 0; i < 300; i++) rx_push(16'h03C0, 1'b0);
    chk("drop_sat", 32'(rx_drop_cnt), 255);
    rx_read(8);
    chk("rx_q_empty", 32'(rx_exp.size()), 0);

    // Reset mid-traffic with both FIFOs half full
    for (int i = 0; i < 4; i++) tx_write(16'h4000 + 16'(i), 1'b1);
    for (int i = 0; i < 4; i++) rx_push(16'h0350 + 16'(i), 1'b1);
    reset = 1'b1; pop = 1'b1; push = 1'b1; D_push = 16'h03DD;
    tick();
    reset = 1'b0; pop = 1'b0; push = 1'b0;
    tx_exp.delete();
    rx_exp.delete();
    chk("mid_rst_pndng", 32'(pndng), 0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 0);
    chk("mid_rst_ovf", 32'(tx_ovf), 0);
    chk("mid_rst_drop", 32'(rx_drop_cnt), 0);
    chk("mid_rst_misaddr", 32'(rx_misaddr_cnt), 0);
    chk("mid_rst_d_pop", 32'(D_pop), 0);

    // Operational again after reset
    tx_write(16'h5A5A, 1'b1);
    rx_push(16'h03EE, 1'b1);
    tx_pop(1);
    rx_read(1);
    chk("post_tx_q", 32'(tx_exp.size()), 0);
    chk("post_rx_q", 32'(rx_exp.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
